// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC sequencer.
package conv_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2, returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// Valid shift register that mirrors the multiplier pipeline latency.
module lat_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic ck,
    input  logic rst_n,
    input  logic din,
    output logic tail,
    output logic any_set_c
);

    logic [DEPTH-1:0] stages;

    // any_set_c covers only the stages behind the tail: zero means the tail holds the last product
    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n) stages <= '0;
                else        stages <= din;
            end
            assign any_set_c = 1'b0;
        end else begin : g_many
            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n) stages <= '0;
                else        stages <= {stages[DEPTH-2:0], din};
            end
            assign any_set_c = |stages[DEPTH-2:0];
        end
    endgenerate

    assign tail = stages[DEPTH-1];

endmodule

// File: rtl/conv_mac_seq.sv
// Sequences one TAPS-wide window through the shared 4x4 multiplier and accumulates the result.
module conv_mac_seq
    import conv_pkg::*;
#(
    parameter int unsigned TAPS    = 3,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned ACC_W   = 10
) (
    input  logic                     ck,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DATA_W*TAPS-1:0]   win_data,
    input  logic [DATA_W*TAPS-1:0]   coef,
    output logic [DATA_W-1:0]        mul_a,
    output logic [DATA_W-1:0]        mul_b,
    input  logic [PROD_W-1:0]        mul_p,
    output logic                     busy,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned IDX_W = clog2(TAPS);

    generate
        if (ACC_W < PROD_W + clog2(TAPS)) begin : g_bad_acc_w
            $error("conv_mac_seq: ACC_W too narrow for TAPS");
        end
        if (MUL_LAT < 1) begin : g_bad_mul_lat
            $error("conv_mac_seq: MUL_LAT must be at least 1");
        end
    endgenerate

    logic [DATA_W-1:0] w_in   [TAPS];
    logic [DATA_W-1:0] c_in   [TAPS];
    logic [DATA_W-1:0] w_snap [TAPS];
    logic [DATA_W-1:0] c_snap [TAPS];

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_unpack
            assign w_in[gi] = win_data[DATA_W*gi +: DATA_W];
            assign c_in[gi] = coef[DATA_W*gi +: DATA_W];
        end
    endgenerate

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx, idx_inc;
    logic [ACC_W-1:0]  acc, acc_nx, acc_sum;
    logic [DATA_W-1:0] mul_a_nx, mul_b_nx;
    logic [ACC_W-1:0]  out_data_nx;
    logic              busy_nx, out_valid_nx, snap_en;
    logic              last_tap_c, pipe_tail, pipe_more_c;

    assign last_tap_c = (idx == IDX_W'(TAPS - 1));
    assign idx_inc    = idx + IDX_W'(1);
    assign acc_sum    = acc + ACC_W'(mul_p);

    lat_pipe #(.DEPTH(MUL_LAT)) u_lat_pipe (
        .ck        (ck),
        .rst_n     (rst_n),
        .din       (state == ISSUE),
        .tail      (pipe_tail),
        .any_set_c (pipe_more_c)
    );

    // State register
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start)                      state_nx = ISSUE;
            ISSUE: if (last_tap_c)                 state_nx = DRAIN;
            DRAIN: if (pipe_tail && !pipe_more_c)  state_nx = DONE;
            DONE:  if (out_ready)                  state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    // Next values of the registered datapath and outputs
    always_comb begin
        idx_nx       = idx;
        acc_nx       = acc;
        mul_a_nx     = '0;
        mul_b_nx     = '0;
        out_data_nx  = out_data;
        snap_en      = 1'b0;
        busy_nx      = (state_nx != IDLE);
        out_valid_nx = (state_nx == DONE);
        if (pipe_tail) acc_nx = acc_sum;
        unique case (state)
            IDLE: begin
                if (start) begin
                    snap_en  = 1'b1;
                    acc_nx   = '0;
                    idx_nx   = '0;
                    mul_a_nx = w_in[0];
                    mul_b_nx = c_in[0];
                end
            end
            ISSUE: begin
                if (!last_tap_c) begin
                    idx_nx   = idx_inc;
                    mul_a_nx = w_snap[idx_inc];
                    mul_b_nx = c_snap[idx_inc];
                end
            end
            DRAIN: begin
                if (state_nx == DONE) out_data_nx = acc_sum;
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            idx       <= idx_nx;
            acc       <= acc_nx;
            mul_a     <= mul_a_nx;
            mul_b     <= mul_b_nx;
            busy      <= busy_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
        end
    end

    // Operand snapshot; only read while busy, so it needs no reset
    always_ff @(posedge ck) begin
        if (snap_en) begin
            w_snap <= w_in;
            c_snap <= c_in;
        end
    end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Scoreboard bench for conv_mac_seq with MUL_LAT=1 and MUL_LAT=3 instances.
module tb_conv_mac_seq;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1 = 1'b0, start2 = 1'b0;
    logic [11:0] win1 = '0, coef1 = '0, win2 = '0, coef2 = '0;
    logic [3:0]  mul_a1, mul_b1, mul_a2, mul_b2;
    logic [7:0]  mul_p1, mul_p2;
    logic        busy1, busy2, out_valid1, out_valid2;
    logic        out_ready1 = 1'b1, out_ready2 = 1'b1;
    logic [9:0]  out_data1, out_data2;

    int errors = 0;
    int checks = 0;
    int q1[$];
    int q2[$];

    always #5 ck = ~ck;

    conv_mac_seq #(.TAPS(3), .MUL_LAT(1), .ACC_W(10)) dut1 (
        .ck(ck), .rst_n(rst_n), .start(start1), .win_data(win1), .coef(coef1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1), .busy(busy1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    conv_mac_seq #(.TAPS(3), .MUL_LAT(3), .ACC_W(10)) dut2 (
        .ck(ck), .rst_n(rst_n), .start(start2), .win_data(win2), .coef(coef2),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2), .busy(busy2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    // Multiplier models: registered product, MUL_LAT stages, no reset
    always_ff @(posedge ck) mul_p1 <= mul_a1 * mul_b1;

    logic [7:0] p2 [3];
    always_ff @(posedge ck) begin
        p2[0] <= mul_a2 * mul_b2;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign mul_p2 = p2[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    // Raise start for one edge (E0) on dut1 and record the expected result.
    task automatic start_op1(input logic [11:0] w, input logic [11:0] c, input int exp);
        win1 = w; coef1 = c; start1 = 1'b1;
        q1.push_back(exp);
        tick(1);
        start1 = 1'b0;
    endtask

    task automatic wait_idle1();
        int n = 0;
        while (busy1 && n < 40) begin
            tick(1);
            n++;
        end
        check("dut1 idle timeout", int'(busy1), 0);
    endtask

    task automatic wait_idle2();
        int n = 0;
        while (busy2 && n < 40) begin
            tick(1);
            n++;
        end
        check("dut2 idle timeout", int'(busy2), 0);
    endtask

    // Monitors: pop and compare at each handshake
    always @(negedge ck) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                errors++; checks++;
                $display("FAIL dut1 unexpected result: got %0d expected none", out_data1);
            end else begin
                check("dut1 result", int'(out_data1), q1.pop_front());
            end
        end
    end

    always @(negedge ck) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                errors++; checks++;
                $display("FAIL dut2 unexpected result: got %0d expected none", out_data2);
            end else begin
                check("dut2 result", int'(out_data2), q2.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge ck);
        #1;
        check("reset busy", int'(busy1), 0);
        check("reset out_valid", int'(out_valid1), 0);
        check("reset out_data", int'(out_data1), 0);
        check("reset mul_a", int'(mul_a1), 0);
        check("reset mul_b", int'(mul_b1), 0);
        rst_n = 1'b1;
        tick(1);

        // Basic: w={1,2,3}, c={4,5,6} -> 32, valid only after E4
        start_op1(12'h321, 12'h654, 32);
        check("E0 busy", int'(busy1), 1);
        check("tap0 a", int'(mul_a1), 1);
        check("tap0 b", int'(mul_b1), 4);
        tick(1);
        check("tap1 a", int'(mul_a1), 2);
        check("tap1 b", int'(mul_b1), 5);
        tick(1);
        check("tap2 a", int'(mul_a1), 3);
        check("tap2 b", int'(mul_b1), 6);
        tick(1);
        check("E3 mul_a idle", int'(mul_a1), 0);
        check("E3 valid", int'(out_valid1), 0);
        tick(1);
        check("E4 valid", int'(out_valid1), 1);
        check("E4 data", int'(out_data1), 32);
        tick(1);
        check("E5 valid", int'(out_valid1), 0);
        check("E5 busy", int'(busy1), 0);
        check("E5 data kept", int'(out_data1), 32);

        // All operands 15 -> 675
        start_op1(12'hFFF, 12'hFFF, 675);
        wait_idle1();

        // Backpressure with ignored start pulses
        out_ready1 = 1'b0;
        start_op1(12'h321, 12'h654, 32);
        tick(4);
        for (int i = 0; i < 5; i++) begin
            win1 = 12'hFFF; coef1 = 12'hFFF; start1 = 1'b1;
            check("bp valid held", int'(out_valid1), 1);
            check("bp data held", int'(out_data1), 32);
            check("bp busy", int'(busy1), 1);
            tick(1);
        end
        out_ready1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        check("post handshake valid", int'(out_valid1), 0);
        check("post handshake busy", int'(busy1), 0);
        start_op1(12'h100, 12'h700, 7);
        wait_idle1();

        // MUL_LAT=3: w=2s, c=3s -> 18, valid after E6
        win2 = 12'h222; coef2 = 12'h333; start2 = 1'b1;
        q2.push_back(18);
        tick(1);
        start2 = 1'b0;
        tick(5);
        check("lat3 E5 valid", int'(out_valid2), 0);
        tick(1);
        check("lat3 E6 valid", int'(out_valid2), 1);
        check("lat3 E6 data", int'(out_data2), 18);
        wait_idle2();

        // Reset while issuing tap 1
        win1 = 12'h321; coef1 = 12'h654; start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #2;
        check("midrst busy", int'(busy1), 0);
        check("midrst valid", int'(out_valid1), 0);
        check("midrst data", int'(out_data1), 0);
        check("midrst mul_a", int'(mul_a1), 0);
        check("midrst mul_b", int'(mul_b1), 0);
        #1;
        rst_n = 1'b1;
        tick(6);
        check("midrst no result", int'(out_valid1), 0);
        start_op1(12'h111, 12'h111, 3);
        wait_idle1();

        // Start held high: one result every 6 cycles, window changed after each start edge
        begin
            logic [11:0] wv [3];
            logic [11:0] cv [3];
            int          ev [3];
            wv[0] = 12'h321; cv[0] = 12'h654; ev[0] = 32;
            wv[1] = 12'h703; cv[1] = 12'h192; ev[1] = 13;
            wv[2] = 12'h21F; cv[2] = 12'h43F; ev[2] = 236;
            start1 = 1'b1;
            for (int r = 0; r < 3; r++) begin
                win1 = wv[r]; coef1 = cv[r];
                q1.push_back(ev[r]);
                tick(1);
                win1 = 12'hFFF;
                tick(3);
                check("tput pre valid", int'(out_valid1), 0);
                tick(1);
                check("tput valid", int'(out_valid1), 1);
                tick(1);
                check("tput post valid", int'(out_valid1), 0);
            end
            start1 = 1'b0;
        end
        wait_idle1();
        tick(3);

        check("dut1 queue drained", q1.size(), 0);
        check("dut2 queue drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_mac_seq.md
# conv_mac_seq

Sequencer for the shared 4x4 pipelined unsigned multiplier in the 1D convolution datapath. On a start pulse it snapshots one TAPS-wide sample window and coefficient set, then issues one tap pair per cycle to the multiplier. It tracks the multiplier pipeline latency, accumulates the returned products, and presents one convolution output word under a valid/ready handshake. It sits between the window/coefficient registers and the multiplier instance.

## Interface
Parameters:
- TAPS, 3: taps per output; 2..16
- MUL_LAT, 1: multiplier pipeline latency in cycles, operand capture to P valid; 1..4
- ACC_W, 10: accumulator/output width; must be >= 8 + clog2(TAPS)

Ports:
- ck  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request one output; sampled only in IDLE
- win_data  in  4*TAPS  sample window; tap i at bits [4i+3:4i]
- coef  in  4*TAPS  coefficients, same packing
- mul_a  out  4  to multiplier A
- mul_b  out  4  to multiplier B
- mul_p  in  8  from multiplier P
- busy  out  1  high in ISSUE, DRAIN, DONE
- out_data  out  ACC_W  accumulated result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result

## Operation
- States and transitions:
  - IDLE: start=1 → ISSUE.
  - ISSUE: after tap TAPS-1 is issued → DRAIN.
  - DRAIN: after the last product is accumulated → DONE.
  - DONE: out_valid & out_ready → IDLE.
- Start edge in IDLE:
  - latches win_data and coef into internal snapshot registers;
  - clears acc and tap index idx.
- ISSUE: for idx = 0..TAPS-1, one tap per cycle:
  - mul_a = w[idx], mul_b = c[idx];
  - a 1 enters the valid pipe (depth MUL_LAT).
- Outside ISSUE, mul_a and mul_b are 0 and a 0 enters the pipe.
- When the valid pipe tail is 1, mul_p is added to acc on the next edge.
- Arithmetic:
  - unsigned;
  - product zero-extended to ACC_W;
  - no overflow is possible under the ACC_W rule.
- DONE:
  - out_data = acc, out_valid = 1;
  - both held stable until out_ready=1.
- out_data keeps its last value after the handshake until the next result.
- Ignored inputs:
  - start while busy=1, including the DONE handshake cycle;
  - out_ready while out_valid=0.
- win_data and coef may change freely after the start edge.

## Timing
- Reset values (async assert):
  - state IDLE;
  - busy, out_valid 0;
  - out_data, acc, idx 0;
  - mul_a, mul_b 0;
  - valid pipe all 0.
- Reset mid-operation:
  - abandons the computation; no out_valid is produced;
  - in-flight products are discarded because the pipe is cleared.
- Numbering: the start-sampling edge is E0. Tap k is driven in the cycle after Ek.
- Last product is accumulated at E(TAPS-1+MUL_LAT+1). out_valid rises after edge E(TAPS+MUL_LAT).
- Handshake at edge H returns to IDLE; next start is accepted at H+1.
- With start held high and out_ready=1, throughput is one result per TAPS+MUL_LAT+2 cycles.
- busy rises after E0 and falls after the handshake edge.

## Structure
- Shared package conv_pkg:
  - DATA_W=4, PROD_W=8;
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - clog2 helper for the ACC_W check.
- Sub-module lat_pipe:
  - MUL_LAT-deep 1-bit shift register, async active-low clear;
  - outputs tail and any-set, used for the DRAIN exit.
- Elaboration-time check fails if ACC_W < 8 + clog2(TAPS) or MUL_LAT < 1.
- Bench multiplier model: registered product, MUL_LAT stages.

## Test plan
- TAPS=3, MUL_LAT=1, w={1,2,3}, c={4,5,6}, out_ready=1 → out_data=32; out_valid high exactly after E4 for 1 cycle.
- All operands 15 → out_data=675 (fits 10 bits), no wrap.
- Backpressure, same stimulus: out_ready low 5 cycles → out_data=32 and out_valid held; start pulses ignored; busy=1; after the handshake, a new start computes w={0,0,1}, c={0,0,7} → 7.
- MUL_LAT=3, w={2,2,2}, c={3,3,3} → out_data=18; out_valid after E6.
- rst_n pulsed low during ISSUE idx=1 → all outputs 0 immediately, no out_valid. Next start with w={1,1,1}, c={1,1,1} → 3, with no stale contribution.
- start held high, out_ready=1, TAPS=3, MUL_LAT=1 → out_valid pulses every 6 cycles. Changing win_data one cycle after each start edge does not alter that result.
